// File: rtl/disp_map_reader.sv
// Reads one frame of disparity words from BRAM port B and streams them out
// on a valid/ready interface through a 2-entry first-word-fall-through FIFO.
module disp_map_reader #(
    parameter int          NUM_WORDS = 1024,
    parameter int          ADDR_STEP = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        en_bram,
    output logic [3:0]  we_bram,
    output logic [31:0] addr_bram,
    input  logic [31:0] dout_bram,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_READ  | issuing reads while FIFO credit allows
    // S_DRAIN | all reads issued, waiting for the last beat to be accepted
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [31:0]      next_addr_q, next_addr_d;
    logic [31:0]      last_addr_q, last_addr_d;
    logic             inflight_q, inflight_last_q;
    logic             done_q, done_d;

    logic [31:0]      fifo_data_q [0:1];
    logic             fifo_last_q [0:1];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q;

    logic             pop, push, head_last, credit_ok, issue, is_last;
    logic [2:0]       occ;

    assign push      = inflight_q;
    assign m_valid   = (count_q != 2'd0);
    assign pop       = m_valid && m_ready;
    assign head_last = fifo_last_q[rd_ptr_q];
    assign m_data    = m_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign m_last    = m_valid && head_last;

    // Words already committed (buffered or in flight) minus the one leaving now.
    assign occ       = {1'b0, count_q} + {2'b00, inflight_q};
    assign credit_ok = occ < (3'd2 + {2'b00, pop});
    assign issue     = (state_q == S_READ) && credit_ok;
    assign is_last   = (rd_idx_q == LAST_IDX);

    assign en_bram   = issue;
    assign we_bram   = 4'b0000;
    assign addr_bram = issue ? next_addr_q : last_addr_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        rd_idx_d    = rd_idx_q;
        next_addr_d = next_addr_q;
        last_addr_d = last_addr_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The done cycle still blocks start so one pulse cannot retrigger.
                if (start && !done_q) begin
                    state_d     = S_READ;
                    rd_idx_d    = '0;
                    next_addr_d = BASE_ADDR;
                end
            end
            S_READ: begin
                if (issue) begin
                    rd_idx_d    = rd_idx_q + 1'b1;
                    next_addr_d = next_addr_q + 32'(ADDR_STEP);
                    last_addr_d = next_addr_q;
                    if (is_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            rd_idx_q        <= '0;
            next_addr_q     <= BASE_ADDR;
            last_addr_q     <= BASE_ADDR;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_data_q[0]  <= 32'h0;
            fifo_data_q[1]  <= 32'h0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
        end else begin
            state_q         <= state_d;
            rd_idx_q        <= rd_idx_d;
            next_addr_q     <= next_addr_d;
            last_addr_q     <= last_addr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue && is_last;
            done_q          <= done_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= dout_bram;
                fifo_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_disp_map_reader.sv
// Bench for disp_map_reader: an 8-word frame and a single-word frame at a non-zero base.
module tb_disp_map_reader;

    localparam int NW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        m_ready = 1'b1;
    logic        en_bram, m_valid, m_last, busy, done;
    logic [3:0]  we_bram;
    logic [31:0] addr_bram, m_data;
    logic [31:0] dout_bram = 32'h0;

    logic        start1 = 1'b0;
    logic        en1, m_valid1, m_last1, busy1, done1;
    logic [3:0]  we1;
    logic [31:0] addr1, m_data1;
    logic [31:0] dout1 = 32'h0;

    int checks = 0;
    int errors = 0;

    // scoreboard state for the 8-word instance
    int          rd_cnt, pop_cnt;
    logic        prev_stall;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    disp_map_reader #(.NUM_WORDS(NW), .ADDR_STEP(4), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .en_bram(en_bram), .we_bram(we_bram),
        .addr_bram(addr_bram), .dout_bram(dout_bram), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done));

    disp_map_reader #(.NUM_WORDS(1), .ADDR_STEP(4), .BASE_ADDR(32'h100)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .en_bram(en1), .we_bram(we1),
        .addr_bram(addr1), .dout_bram(dout1), .m_data(m_data1), .m_valid(m_valid1),
        .m_ready(1'b1), .m_last(m_last1), .busy(busy1), .done(done1));

    // BRAM models with one-cycle read latency; word i of frame 0 is A000_0000+i.
    always @(posedge clk) begin
        if (en_bram) dout_bram <= 32'hA000_0000 + (addr_bram >> 2);
        if (en1)     dout1     <= 32'hC000_0000 ^ addr1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic st, input logic rdy);
        @(posedge clk);
        #1;
        start   = st;
        m_ready = rdy;
        #1;
    endtask

    task automatic sb_reset();
        rd_cnt     = 0;
        pop_cnt    = 0;
        prev_stall = 1'b0;
        prev_data  = 32'h0;
    endtask

    // Per-cycle reference: in-order beats, read addresses, credit bound, stall hold.
    task automatic cycle_check();
        logic pop;
        int   outstanding;
        pop         = m_valid && m_ready;
        outstanding = rd_cnt - pop_cnt;
        chk("we_zero", {28'h0, we_bram}, 32'h0);
        if (prev_stall) begin
            chk("hold_valid", {31'h0, m_valid}, 32'h1);
            chk("hold_data", m_data, prev_data);
        end
        if (en_bram) begin
            chk("credit", {31'h0, logic'((outstanding - int'(pop)) < 2)}, 32'h1);
            chk("rd_addr", addr_bram, 32'(rd_cnt * 4));
            rd_cnt++;
        end
        if (pop) begin
            chk("beat_data", m_data, 32'hA000_0000 + 32'(pop_cnt));
            chk("beat_last", {31'h0, m_last}, {31'h0, logic'(pop_cnt == NW - 1)});
            pop_cnt++;
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    endtask

    task automatic run_to_done(input logic rnd, input int budget, output int cycles);
        logic finished = 1'b0;
        cycles = 0;
        while (!finished && cycles < budget) begin
            step(1'b0, rnd ? logic'($urandom_range(1, 0)) : 1'b1);
            cycle_check();
            cycles++;
            if (done) finished = 1'b1;
        end
        if (!finished) chk("done_timeout", 32'h0, 32'h1);
        chk("beats_total", 32'(pop_cnt), 32'(NW));
        chk("reads_total", 32'(rd_cnt), 32'(NW));
        chk("busy_in_done", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int  cyc;
        logic st;
        logic en_exp, v_exp, busy_exp;

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_en", {31'h0, en_bram}, 32'h0);
        chk("rst_addr", addr_bram, 32'h0);
        chk("rst_valid", {31'h0, m_valid}, 32'h0);
        chk("rst_data", m_data, 32'h0);
        chk("rst_last", {31'h0, m_last}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_addr1", addr1, 32'h100);

        // Frame at full rate, with extra start pulses at cycles 4, 11 (ignored) and 12.
        sb_reset();
        for (int c = 0; c <= 13; c++) begin
            st = (c == 0 || c == 4 || c == 11 || c == 12);
            step(st, 1'b1);
            if (c == 13) sb_reset();
            cycle_check();
            en_exp   = (c >= 1 && c <= 8) || c == 13;
            v_exp    = (c >= 3 && c <= 10);
            busy_exp = (c >= 1 && c <= 10) || c == 13;
            chk($sformatf("c%0d_en", c), {31'h0, en_bram}, {31'h0, en_exp});
            if (en_exp) chk($sformatf("c%0d_addr", c), addr_bram, (c == 13) ? 32'h0 : 32'(4 * (c - 1)));
            chk($sformatf("c%0d_valid", c), {31'h0, m_valid}, {31'h0, v_exp});
            if (v_exp) chk($sformatf("c%0d_data", c), m_data, 32'hA000_0000 + 32'(c - 3));
            chk($sformatf("c%0d_last", c), {31'h0, m_last}, {31'h0, logic'(c == 10)});
            chk($sformatf("c%0d_done", c), {31'h0, done}, {31'h0, logic'(c == 11)});
            chk($sformatf("c%0d_busy", c), {31'h0, busy}, {31'h0, busy_exp});
        end
        run_to_done(1'b0, 50, cyc);

        // Random backpressure.
        for (int r = 0; r < 3; r++) begin
            sb_reset();
            step(1'b1, 1'b1);
            cycle_check();
            run_to_done(1'b1, 300, cyc);
        end

        // Consumer stalled for 20 cycles, then released.
        sb_reset();
        step(1'b1, 1'b0);
        cycle_check();
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0);
            cycle_check();
        end
        chk("stall_reads", 32'(rd_cnt), 32'h2);
        chk("stall_valid", {31'h0, m_valid}, 32'h1);
        chk("stall_data", m_data, 32'hA000_0000);
        run_to_done(1'b0, 50, cyc);
        chk("release_rate", 32'(cyc), 32'(NW + 1));

        // Reset in cycle 5 of a frame.
        sb_reset();
        step(1'b1, 1'b1);
        cycle_check();
        for (int c = 1; c <= 5; c++) begin
            step(1'b0, 1'b1);
            cycle_check();
        end
        rst = 1'b0;
        step(1'b0, 1'b1);
        chk("abort_valid", {31'h0, m_valid}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_en", {31'h0, en_bram}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1);
            chk("abort_no_done", {31'h0, done}, 32'h0);
            chk("abort_idle", {31'h0, busy}, 32'h0);
        end
        sb_reset();
        step(1'b1, 1'b1);
        cycle_check();
        run_to_done(1'b0, 50, cyc);

        // Single-word frame at base 0x100.
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk);
            #1 start1 = (c == 0);
            #1;
            chk($sformatf("w1_c%0d_en", c), {31'h0, en1}, {31'h0, logic'(c == 1)});
            if (c == 1) chk("w1_addr", addr1, 32'h100);
            chk($sformatf("w1_c%0d_valid", c), {31'h0, m_valid1}, {31'h0, logic'(c == 3)});
            if (c == 3) begin
                chk("w1_data", m_data1, 32'hC000_0100);
                chk("w1_last", {31'h0, m_last1}, 32'h1);
            end
            chk($sformatf("w1_c%0d_done", c), {31'h0, done1}, {31'h0, logic'(c == 4)});
            chk($sformatf("w1_c%0d_busy", c), {31'h0, busy1}, {31'h0, logic'(c >= 1 && c <= 3)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
